// File: rtl/pipelined_ripple_adder.sv
// Purpose: WIDTH-bit adder built from SEG_WIDTH-bit ripple segments, one register stage per segment; optional ovf port under PIPELINED_RIPPLE_ADDER_OVF_EN.
// Latency: STAGES = WIDTH/SEG_WIDTH cycles from input transfer to out_valid; one beat per cycle when unstalled.
// Backpressure: per-stage valids, bubbles collapse, in_ready is combinational from out_ready through the stage chain (no skid slack).
module pipelined_ripple_adder #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / SEG_WIDTH;

  logic [STAGES-1:0] stgVld;
  logic [STAGES-1:0] stgAdv;
  logic [STAGES-1:0] stgLoad;
  logic [STAGES:1]   fullAbove;
  logic              inXfer;

  // A stage is blocked only when every stage after it is full and the output is stalled.
  always_comb begin
    fullAbove[STAGES] = 1'b1;
    for (int k = STAGES - 1; k >= 1; k--) begin
      fullAbove[k] = fullAbove[k+1] & stgVld[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      stgAdv[k] = stgVld[k] & ~(fullAbove[k+1] & ~out_ready);
    end
  end

  assign in_ready = ~stgVld[0] | stgAdv[0];
  assign inXfer   = in_valid & in_ready;

  // Stage 0 loads on an input transfer; every later stage loads when its predecessor advances.
  always_comb begin
    stgLoad[0] = inXfer;
    for (int k = 1; k < STAGES; k++) begin
      stgLoad[k] = stgAdv[k-1];
    end
  end

  // Valid bits: set on load, cleared once the beat has moved on and nothing replaced it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stgVld <= '0;
    end else begin
      stgVld <= stgLoad | (stgVld & ~stgAdv);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    localparam int LO   = k * SEG_WIDTH;
    localparam int DONE = LO + SEG_WIDTH;
    localparam int REM  = WIDTH - DONE;

    // curA/curB hold only the operand bits not yet summed; bit 0 lines up with bit LO.
    logic [WIDTH-LO-1:0]  curA;
    logic [WIDTH-LO-1:0]  curB;
    logic                 curC;
    logic [SEG_WIDTH-1:0] segP;
    logic [SEG_WIDTH-1:0] segG;
    logic [SEG_WIDTH-1:0] segS;
    logic [SEG_WIDTH:0]   segCv;
    logic [DONE-1:0]      nxtSum;
    logic [DONE-1:0]      nxtP;
    logic [DONE-1:0]      nxtG;
    logic [DONE-1:0]      accSum;
    logic [DONE-1:0]      accP;
    logic [DONE-1:0]      accG;
    logic                 accC;

    if (k == 0) begin : gHead
      assign curA   = a;
      assign curB   = b;
      assign curC   = cin;
      assign nxtSum = segS;
      assign nxtP   = segP;
      assign nxtG   = segG;
    end else begin : gBody
      assign curA   = gStage[k-1].gFwd.opA;
      assign curB   = gStage[k-1].gFwd.opB;
      assign curC   = gStage[k-1].accC;
      assign nxtSum = {segS, gStage[k-1].accSum};
      assign nxtP   = {segP, gStage[k-1].accP};
      assign nxtG   = {segG, gStage[k-1].accG};
    end

    assign segP = curA[SEG_WIDTH-1:0] ^ curB[SEG_WIDTH-1:0];
    assign segG = curA[SEG_WIDTH-1:0] & curB[SEG_WIDTH-1:0];
    assign segS = segP ^ segCv[SEG_WIDTH-1:0];

    // Full-adder ripple across this segment; segCv[i] is the carry into bit LO+i.
    always_comb begin
      segCv[0] = curC;
      for (int i = 0; i < SEG_WIDTH; i++) begin
        segCv[i+1] = segG[i] | (segP[i] & segCv[i]);
      end
    end

    // Finished low bits and the segment carry travel with the beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        accSum <= '0;
        accP   <= '0;
        accG   <= '0;
        accC   <= 1'b0;
      end else if (stgLoad[k]) begin
        accSum <= nxtSum;
        accP   <= nxtP;
        accG   <= nxtG;
        accC   <= segCv[SEG_WIDTH];
      end
    end

    if (REM > 0) begin : gFwd
      logic [REM-1:0] opA;
      logic [REM-1:0] opB;

      // Operand bits still to be summed move down one stage with the beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opA <= '0;
          opB <= '0;
        end else if (stgLoad[k]) begin
          opA <= curA[WIDTH-LO-1:SEG_WIDTH];
          opB <= curB[WIDTH-LO-1:SEG_WIDTH];
        end
      end
    end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : gOvf
      logic ovfReg;

      // Signed overflow: carry into the MSB differs from the carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovfReg <= 1'b0;
        end else if (stgLoad[k]) begin
          ovfReg <= segCv[SEG_WIDTH-1] ^ segCv[SEG_WIDTH];
        end
      end
    end
`endif
  end

  assign out_valid = stgVld[STAGES-1];
  assign sum       = gStage[STAGES-1].accSum;
  assign p_out     = gStage[STAGES-1].accP;
  assign g_out     = gStage[STAGES-1].accG;
  assign cout      = gStage[STAGES-1].accC;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  assign ovf       = gStage[STAGES-1].gOvf.ovfReg;
`endif

endmodule
